// File: rtl/fifo_pkg.sv
// Shared width helpers and parameter sanity check for the fifo_sync family.
// The FIFO_SYNC_ERR_EN macro (consumed by fifo_sync) does not affect this package.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time rejection of a non power-of-two depth or out-of-range thresholds.
`define FIFO_PARAM_CHECK(D, AF, AE) \
  if (((D) < 2) || (((D) & ((D) - 1)) != 0) || ((AF) < 1) || ((AF) > (D)) || \
      ((AE) < 0) || ((AE) > ((D) - 1))) begin : g_bad_params \
    $error("fifo_sync: illegal DEPTH/AFULL_TH/AEMPTY_TH combination"); \
  end

package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register with synchronous active-high reset and increment enable.
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Power-of-two depth means the pointer wraps by plain overflow.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync.sv
// Parametrised show-ahead synchronous FIFO with occupancy count and almost flags.
// Define FIFO_SYNC_ERR_EN to add the sticky ovf/udf error ports.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [BITS-1:0]           din,
  output logic [BITS-1:0]           dout,
  output logic                      full,
  output logic                      pndng,
  output logic                      afull,
  output logic                      aempty,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef FIFO_SYNC_ERR_EN
  ,
  output logic                      ovf,
  output logic                      udf
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  `FIFO_PARAM_CHECK(DEPTH, AFULL_TH, AEMPTY_TH)

  logic [BITS-1:0] mem_q [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic            push_ok;
  logic            pop_ok;

  // A push into a full FIFO is only taken when a pop frees the head slot in the same edge.
  assign pop_ok  = pop & pndng;
  assign push_ok = push & (~full | pop_ok);

  fifo_ptr #(.W(PW)) u_wp (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push_ok),
    .ptr_o (wp)
  );

  fifo_ptr #(.W(PW)) u_rp (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop_ok),
    .ptr_o (rp)
  );

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp] <= din;
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count  = count_q;
  assign full   = (count_q == DEPTH_C);
  assign pndng  = (count_q != '0);
  assign afull  = (count_q >= AFULL_C);
  assign aempty = (count_q <= AEMPTY_C);
  assign dout   = pndng ? mem_q[rp] : '0;

`ifdef FIFO_SYNC_ERR_EN
  logic ovf_q;
  logic udf_q;

  // Both error flags hold until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push && !push_ok) ovf_q <= 1'b1;
      if (pop && !pndng)    udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule
